dma_desc_queue: RTL and testbench
=================================

// Module: dma_desc_queue
// PURPOSE
//  Descriptor queue between the CSR manager and dma_engine.
//  - Buffers descriptors written by csr_mgr (one go pulse each).
//  - Presents the head entry to the engine over a show-ahead not_empty/rdack handshake.
//  - Tracks issued vs completed descriptors and reports occupancy, overflow and
//    completion-protocol errors for the CSR status word.
// PARAMETERS
//  DATA_W   256  width of one packed dma_pkg::t_dma_descriptor
//  DEPTH    16   queue entries; power of two, >= 2
//  CNT_W    32   width of issued/completed/drop counters
// PORTS
//  clk               in   1                      clock
//  reset             in   1                      async active-high reset
//  desc_wr_data      in   DATA_W                 descriptor from CSR map
//  desc_wr_en        in   1                      1-cycle go pulse
//  desc_not_full     out  1                      space available
//  stop_descriptors  in   1                      CSR control: hold issue
//  flush             in   1                      1-cycle pulse: discard queued entries
//  desc_rd_data      out  DATA_W                 head descriptor
//  desc_not_empty    out  1                      head valid for engine
//  desc_rdack        in   1                      engine pops head
//  desc_done         in   1                      engine finished one descriptor
//  fifo_count        out  $clog2(DEPTH)+1        queued entries
//  outstanding       out  $clog2(DEPTH)+1        popped, not yet done
//  issued_count      out  CNT_W                  total pops
//  completed_count   out  CNT_W                  total accepted dones
//  drop_count        out  CNT_W                  writes lost while full
//  overflow          out  1                      sticky: a write was dropped
//  done_err          out  1                      sticky: done with outstanding==0
//  busy              out  1                      (fifo_count!=0)|(outstanding!=0)
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - all pointers, counts, counters and sticky flags = 0
//    - desc_not_full = 1, desc_not_empty = 0, desc_rd_data = 0
//  - Storage: circular buffer of DEPTH registers.
//    - wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally.
//    - Full/empty are derived from fifo_count only.
//  - Write: accepted iff desc_wr_en & (fifo_count != DEPTH).
//    - Data is stored at wr_ptr; wr_ptr++.
//  - Write when full: dropped even if a pop occurs the same cycle (no bypass).
//    - drop_count++ (saturating at all-ones); overflow <= 1.
//  - desc_not_full = (fifo_count != DEPTH), combinational from registered count.
//  - Issue: desc_not_empty = (fifo_count != 0) & ~stop_descriptors.
//    - desc_rd_data = mem[rd_ptr], show-ahead: valid in the same cycle as not_empty.
//  - Pop: accepted iff desc_rdack & desc_not_empty.
//    - rd_ptr++; outstanding++; issued_count++ (wraps).
//    - desc_rdack while desc_not_empty = 0 is ignored.
//  - A write into an empty queue becomes visible 1 cycle later (no write->read bypass).
//  - Simultaneous accepted write + pop: fifo_count unchanged; both pointers advance.
//  - Done:
//    - if outstanding != 0: outstanding--; completed_count++ (wraps).
//    - if outstanding == 0: ignored, and done_err <= 1.
//  - Simultaneous accepted pop + done: outstanding unchanged; both counters increment.
//  - outstanding never exceeds DEPTH.
//    - A pop that would push it above DEPTH is blocked: desc_not_empty also
//      requires outstanding < DEPTH.
//  - flush (highest priority):
//    - rd_ptr <= wr_ptr, fifo_count <= 0.
//    - A same-cycle write is discarded and not counted as a drop; a same-cycle pop is ignored.
//    - outstanding, counters and sticky flags are unaffected; in-flight work completes normally.
//  - stop_descriptors only gates issue.
//    - Writes continue while stopped; deasserting stop resumes from the current head.
//  - Sticky flags and counters clear only on reset.
//  - Reset mid-operation: all queued and outstanding state is lost.
//    - Any desc_done arriving after release sets done_err.
// TESTING
//  - Reset, write 3 descriptors (0xA,0xB,0xC):
//    -> fifo_count=3; not_empty 1 cycle after the first write; rd_data=0xA.
//  - Pop 3 with rdack, then 3 dones
//    -> rd_data sequence A,B,C; issued=3; outstanding 3->0; completed=3; busy=0.
//  - Fill 16, write a 17th with a pop in the same cycle
//    -> 17th dropped; drop_count=1; overflow=1; fifo_count=15.
//  - stop_descriptors=1 with 2 queued
//    -> not_empty=0 and rdack ignored; release stop -> not_empty=1 with the same head.
//  - desc_done with outstanding=0 -> done_err=1, completed_count unchanged.
//  - Wrap: 40 write/pop/done cycles with DEPTH=16
//    -> data order preserved; issued=completed=40.
//  - Flush with 5 queued, 2 outstanding
//    -> fifo_count=0, outstanding=2; 2 dones -> busy=0.

Source files
------------

// File: rtl/dma_desc_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_desc_queue_if
// Description : Handshake and status bundle between csr_mgr / dma_engine and
//               the descriptor queue. The slave modport is the queue's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_desc_queue_if #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    // Write side (csr_mgr)
    logic [DATA_W-1:0] desc_wr_data;
    logic              desc_wr_en;
    logic              desc_not_full;
    logic              stop_descriptors;
    logic              flush;
    // Read side (dma_engine)
    logic [DATA_W-1:0] desc_rd_data;
    logic              desc_not_empty;
    logic              desc_rdack;
    logic              desc_done;
    // Status
    logic [c_CW-1:0]   fifo_count;
    logic [c_CW-1:0]   outstanding;
    logic [CNT_W-1:0]  issued_count;
    logic [CNT_W-1:0]  completed_count;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;
    logic              done_err;
    logic              busy;

    modport slave (
        input  desc_wr_data, desc_wr_en, stop_descriptors, flush,
               desc_rdack, desc_done,
        output desc_not_full, desc_rd_data, desc_not_empty,
               fifo_count, outstanding, issued_count, completed_count,
               drop_count, overflow, done_err, busy
    );

    modport master (
        output desc_wr_data, desc_wr_en, stop_descriptors, flush,
               desc_rdack, desc_done,
        input  desc_not_full, desc_rd_data, desc_not_empty,
               fifo_count, outstanding, issued_count, completed_count,
               drop_count, overflow, done_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dma_desc_queue.sv
`default_nettype none
// ============================================================================
// Module      : dma_desc_queue
// Description : Circular descriptor queue with show-ahead head, issue/complete
//               tracking, drop counting and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_desc_queue #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dma_desc_queue_if.slave  bus
);
    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_fifo_count;
    logic [c_CW-1:0]   r_outstanding;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_completed;
    logic [CNT_W-1:0]  r_drop;
    logic              r_overflow;
    logic              r_done_err;

    logic w_full;
    logic w_empty;
    logic w_not_empty;
    logic w_wr_acc;
    logic w_wr_drop;
    logic w_pop;
    logic w_done_ok;
    logic w_done_bad;

    // Full/empty come only from the registered count; a pop never frees a
    // slot for a write in the same cycle.
    assign w_full      = (r_fifo_count == c_DEPTH);
    assign w_empty     = (r_fifo_count == '0);
    // Issue is held off by stop and by outstanding reaching DEPTH.
    assign w_not_empty = ~w_empty & ~bus.stop_descriptors & (r_outstanding < c_DEPTH);

    // Flush wins over everything: same-cycle write is discarded silently and
    // a same-cycle pop is ignored.
    assign w_wr_acc    = bus.desc_wr_en & ~w_full & ~bus.flush;
    assign w_wr_drop   = bus.desc_wr_en &  w_full & ~bus.flush;
    assign w_pop       = bus.desc_rdack & w_not_empty & ~bus.flush;
    assign w_done_ok   = bus.desc_done & (r_outstanding != '0);
    assign w_done_bad  = bus.desc_done & (r_outstanding == '0);

    // Descriptor storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.desc_wr_data;
        end
    end

    // Read/write pointers; flush snaps the head onto the tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (bus.flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
        end
    end

    // Queue occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_count <= '0;
        end else if (bus.flush) begin
            r_fifo_count <= '0;
        end else begin
            case ({w_wr_acc, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_CW'(1);
                2'b01:   r_fifo_count <= r_fifo_count - c_CW'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Descriptors handed to the engine but not yet reported done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_pop, w_done_ok})
                2'b10:   r_outstanding <= r_outstanding + c_CW'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Lifetime counters: issued/completed wrap, drops saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued    <= '0;
            r_completed <= '0;
            r_drop      <= '0;
        end else begin
            if (w_pop) begin
                r_issued <= r_issued + CNT_W'(1);
            end
            if (w_done_ok) begin
                r_completed <= r_completed + CNT_W'(1);
            end
            if (w_wr_drop && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_W'(1);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_done_bad) begin
                r_done_err <= 1'b1;
            end
        end
    end

    assign bus.desc_not_full   = ~w_full;
    assign bus.desc_not_empty  = w_not_empty;
    assign bus.desc_rd_data    = r_mem[r_rd_ptr];
    assign bus.fifo_count      = r_fifo_count;
    assign bus.outstanding     = r_outstanding;
    assign bus.issued_count    = r_issued;
    assign bus.completed_count = r_completed;
    assign bus.drop_count      = r_drop;
    assign bus.overflow        = r_overflow;
    assign bus.done_err        = r_done_err;
    assign bus.busy            = (r_fifo_count != '0) | (r_outstanding != '0);

endmodule
`default_nettype wire

// File: tb/tb_dma_desc_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_desc_queue
// Description : Self-checking bench for dma_desc_queue: directed vector table,
//               corner-case sequences and random traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_desc_queue;
    localparam int c_DW    = 256;
    localparam int c_DEPTH = 16;
    localparam int c_CNTW  = 32;

    logic clk;
    logic reset;

    dma_desc_queue_if #(.DATA_W(c_DW), .DEPTH(c_DEPTH), .CNT_W(c_CNTW)) bus ();

    dma_desc_queue #(.DATA_W(c_DW), .DEPTH(c_DEPTH), .CNT_W(c_CNTW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: an ordered list of queued descriptors plus counts.
    logic [c_DW-1:0]   m_q [$];
    int                m_out;
    logic [c_CNTW-1:0] m_issued;
    logic [c_CNTW-1:0] m_completed;
    logic [c_CNTW-1:0] m_drop;
    bit                m_ovf;
    bit                m_derr;
    bit                m_stop;

    typedef struct {
        bit              we;
        logic [c_DW-1:0] wd;
        bit              ra;
        bit              dn;
        int              e_cnt;
        bit              e_ne;
        int              e_out;
        logic [c_DW-1:0] e_rd;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out       = 0;
        m_issued    = '0;
        m_completed = '0;
        m_drop      = '0;
        m_ovf       = 1'b0;
        m_derr      = 1'b0;
    endtask

    task automatic model_check();
        bit vis;
        vis = (m_q.size() != 0) && !m_stop && (m_out < c_DEPTH);
        chk("fifo_count", c_DW'(bus.fifo_count), c_DW'(m_q.size()));
        chk("outstanding", c_DW'(bus.outstanding), c_DW'(m_out));
        chk("issued", c_DW'(bus.issued_count), c_DW'(m_issued));
        chk("completed", c_DW'(bus.completed_count), c_DW'(m_completed));
        chk("drop", c_DW'(bus.drop_count), c_DW'(m_drop));
        chk("overflow", c_DW'(bus.overflow), c_DW'(m_ovf));
        chk("done_err", c_DW'(bus.done_err), c_DW'(m_derr));
        chk("busy", c_DW'(bus.busy), c_DW'((m_q.size() != 0) || (m_out != 0)));
        chk("not_full", c_DW'(bus.desc_not_full), c_DW'(m_q.size() != c_DEPTH));
        chk("not_empty", c_DW'(bus.desc_not_empty), c_DW'(vis));
        if (vis) chk("rd_data", bus.desc_rd_data, m_q[0]);
    endtask

    // One clock: drive inputs at the falling edge, advance the model by the
    // stated rules, check everything at the next falling edge.
    task automatic step(input bit we, input logic [c_DW-1:0] wd, input bit ra,
                        input bit dn, input bit st, input bit fl);
        bit vis;
        bit full;
        int out0;
        bus.desc_wr_en       = we;
        bus.desc_wr_data     = wd;
        bus.desc_rdack       = ra;
        bus.desc_done        = dn;
        bus.stop_descriptors = st;
        bus.flush            = fl;
        m_stop = st;
        vis  = (m_q.size() != 0) && !st && (m_out < c_DEPTH);
        full = (m_q.size() == c_DEPTH);
        out0 = m_out;
        if (fl) begin
            m_q.delete();
        end else begin
            if (ra && vis) begin
                void'(m_q.pop_front());
                m_out++;
                m_issued++;
            end
            if (we) begin
                if (full) begin
                    if (m_drop != '1) m_drop++;
                    m_ovf = 1'b1;
                end else begin
                    m_q.push_back(wd);
                end
            end
        end
        if (dn) begin
            if (out0 != 0) begin
                m_out--;
                m_completed++;
            end else begin
                m_derr = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        bus.desc_wr_en = 0; bus.desc_wr_data = '0; bus.desc_rdack = 0;
        bus.desc_done = 0; bus.stop_descriptors = 0; bus.flush = 0;
        m_stop = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        @(negedge clk);
    endtask

    logic [c_CNTW-1:0] base_iss;
    logic [c_CNTW-1:0] base_cmp;
    logic [c_DW-1:0]   rnd;

    initial begin
        reset = 1'b1;
        model_reset();
        // Directed vectors: write A,B,C, pop three, complete three.
        tbl[0] = '{1, 256'hA, 0, 0, 1, 1, 0, 256'hA};
        tbl[1] = '{1, 256'hB, 0, 0, 2, 1, 0, 256'hA};
        tbl[2] = '{1, 256'hC, 0, 0, 3, 1, 0, 256'hA};
        tbl[3] = '{0, 256'h0, 1, 0, 2, 1, 1, 256'hB};
        tbl[4] = '{0, 256'h0, 1, 0, 1, 1, 2, 256'hC};
        tbl[5] = '{0, 256'h0, 1, 0, 0, 0, 3, 256'h0};
        tbl[6] = '{0, 256'h0, 0, 1, 0, 0, 2, 256'h0};
        tbl[7] = '{0, 256'h0, 0, 1, 0, 0, 1, 256'h0};
        tbl[8] = '{0, 256'h0, 0, 1, 0, 0, 0, 256'h0};

        do_reset();
        chk("rst_fifo_count", c_DW'(bus.fifo_count), 0);
        chk("rst_not_full", c_DW'(bus.desc_not_full), 1);
        chk("rst_not_empty", c_DW'(bus.desc_not_empty), 0);
        chk("rst_rd_data", bus.desc_rd_data, 0);
        model_check();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].ra, tbl[i].dn, 0, 0);
            chk($sformatf("vec%0d_count", i), c_DW'(bus.fifo_count), c_DW'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_ne", i), c_DW'(bus.desc_not_empty), c_DW'(tbl[i].e_ne));
            chk($sformatf("vec%0d_out", i), c_DW'(bus.outstanding), c_DW'(tbl[i].e_out));
            if (tbl[i].e_ne) chk($sformatf("vec%0d_rd", i), bus.desc_rd_data, tbl[i].e_rd);
        end
        chk("vec_issued", c_DW'(bus.issued_count), 3);
        chk("vec_completed", c_DW'(bus.completed_count), 3);
        chk("vec_busy", c_DW'(bus.busy), 0);

        // Fill to DEPTH, then a 17th write alongside a pop is still dropped.
        for (int i = 0; i < c_DEPTH; i++) step(1, c_DW'(256 + i), 0, 0, 0, 0);
        chk("full_not_full", c_DW'(bus.desc_not_full), 0);
        step(1, 256'h1FF, 1, 0, 0, 0);
        chk("ovf_drop", c_DW'(bus.drop_count), 1);
        chk("ovf_flag", c_DW'(bus.overflow), 1);
        chk("ovf_count", c_DW'(bus.fifo_count), 15);
        for (int i = 0; i < 15; i++) step(0, '0, 1, 1, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        chk("ovf_busy", c_DW'(bus.busy), 0);

        // Outstanding ceiling blocks issue until a done arrives.
        for (int i = 0; i < c_DEPTH; i++) step(1, c_DW'(512 + i), 0, 0, 0, 0);
        for (int i = 0; i < c_DEPTH; i++) step(0, '0, 1, 0, 0, 0);
        step(1, 256'h2AA, 0, 0, 0, 0);
        base_iss = bus.issued_count;
        chk("lim_ne", c_DW'(bus.desc_not_empty), 0);
        step(0, '0, 1, 0, 0, 0);
        chk("lim_issued", c_DW'(bus.issued_count), c_DW'(base_iss));
        step(0, '0, 0, 1, 0, 0);
        chk("lim_ne_after_done", c_DW'(bus.desc_not_empty), 1);
        chk("lim_head", bus.desc_rd_data, 256'h2AA);
        step(0, '0, 1, 0, 0, 0);
        for (int i = 0; i < c_DEPTH; i++) step(0, '0, 0, 1, 0, 0);

        // Stop holds issue; writes still land; release resumes at same head.
        step(1, 256'hD1, 0, 0, 1, 0);
        step(1, 256'hD2, 0, 0, 1, 0);
        chk("stop_ne", c_DW'(bus.desc_not_empty), 0);
        base_iss = bus.issued_count;
        step(0, '0, 1, 0, 1, 0);
        chk("stop_count", c_DW'(bus.fifo_count), 2);
        chk("stop_issued", c_DW'(bus.issued_count), c_DW'(base_iss));
        step(0, '0, 0, 0, 0, 0);
        chk("stop_release_ne", c_DW'(bus.desc_not_empty), 1);
        chk("stop_release_head", bus.desc_rd_data, 256'hD1);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 1, 0, 0);
        step(0, '0, 0, 1, 0, 0);

        // Done with nothing outstanding.
        chk("derr_before", c_DW'(bus.done_err), 0);
        base_cmp = bus.completed_count;
        step(0, '0, 0, 1, 0, 0);
        chk("derr_flag", c_DW'(bus.done_err), 1);
        chk("derr_completed", c_DW'(bus.completed_count), c_DW'(base_cmp));

        // Wrap through the buffer several times.
        base_iss = bus.issued_count;
        base_cmp = bus.completed_count;
        for (int i = 0; i < 40; i++) begin
            step(1, c_DW'(32'hC000 + i), 0, 0, 0, 0);
            chk($sformatf("wrap%0d_rd", i), bus.desc_rd_data, c_DW'(32'hC000 + i));
            step(0, '0, 1, 0, 0, 0);
            step(0, '0, 0, 1, 0, 0);
        end
        chk("wrap_issued", c_DW'(bus.issued_count - base_iss), 40);
        chk("wrap_completed", c_DW'(bus.completed_count - base_cmp), 40);

        // Flush with 5 queued and 2 outstanding, plus a same-cycle write.
        for (int i = 0; i < 7; i++) step(1, c_DW'(32'hF00 + i), 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(1, 256'hEE, 0, 0, 0, 1);
        chk("flush_count", c_DW'(bus.fifo_count), 0);
        chk("flush_out", c_DW'(bus.outstanding), 2);
        chk("flush_drop", c_DW'(bus.drop_count), 1);
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        chk("flush_busy", c_DW'(bus.busy), 0);
        step(1, 256'hF0, 0, 0, 0, 0);
        chk("flush_new_head", bus.desc_rd_data, 256'hF0);
        step(0, '0, 1, 1, 0, 0);
        step(0, '0, 0, 1, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            step(($urandom() % 2) == 0, rnd, ($urandom() % 4) != 0,
                 ($urandom() % 3) == 0, ($urandom() % 8) == 0,
                 ($urandom() % 64) == 0);
        end

        // Reset in the middle of traffic loses everything in flight.
        step(1, 256'h77, 0, 0, 0, 0);
        step(1, 256'h78, 1, 0, 0, 0);
        do_reset();
        chk("mid_rst_count", c_DW'(bus.fifo_count), 0);
        chk("mid_rst_out", c_DW'(bus.outstanding), 0);
        chk("mid_rst_issued", c_DW'(bus.issued_count), 0);
        chk("mid_rst_derr", c_DW'(bus.done_err), 0);
        step(0, '0, 0, 1, 0, 0);
        chk("mid_rst_done_err", c_DW'(bus.done_err), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
